counter_udm: RTL and testbench



---
 rtl/counters_pkg.sv | 22 ++
 rtl/counter_udm_if.sv | 22 ++
 rtl/ffd_en_arn.sv | 25 ++
 rtl/counter_udm.sv | 79 +++++++
 tb/tb_counter_udm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/counters_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counters_pkg
//  Description : Shared limit-mode constants and load clamping for counters.
//  Revision    : 1.0
// ============================================================================
package counters_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // Loads outside the count range snap to the top of the range.
   function automatic logic [31:0] clamp_load(input logic [31:0]       din,
                                              input longint unsigned   modulus);
      logic [63:0] w_din64;
      w_din64 = {32'd0, din};
      if (w_din64 < modulus) return din;
      return 32'(modulus - 64'd1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_udm_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_udm_if
//  Description : Control and status bundle of the up/down modulo counter.
//  Revision    : 1.0
// ============================================================================
interface counter_udm_if #(
   parameter int N = 4
);
   logic         clr;
   logic         load;
   logic [N-1:0] din;
   logic         en;
   logic         up;
   logic [N-1:0] count;
   logic         tc;
   logic         ovf;

   modport master (output clr, load, din, en, up, input  count, tc, ovf);
   modport slave  (input  clr, load, din, en, up, output count, tc, ovf);
endinterface
`default_nettype wire

// File: rtl/ffd_en_arn.sv
`default_nettype none
// ============================================================================
//  Module      : ffd_en_arn
//  Description : W-bit D register with enable, async active-low reset to 0.
//  Revision    : 1.0
// ============================================================================
module ffd_en_arn #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)   r_q <= '0;
      else if (i_en) r_q <= i_d;
   end

   assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/counter_udm.sv
`default_nettype none
// ============================================================================
//  Module      : counter_udm
//  Description : Synchronous up/down modulo counter, wrap or saturate limits.
//  Revision    : 1.0
// ============================================================================
module counter_udm
   import counters_pkg::*;
#(
   parameter int              N   = 4,
   parameter longint unsigned MOD = 10,
   parameter int              SAT = MODE_WRAP
) (
   input  logic           clk,
   input  logic           arst_n,
   counter_udm_if.slave   bus
);
   if (N < 1 || N > 32 || MOD < 2 || MOD > (64'd1 << N)) begin : g_param_check
      $error("counter_udm: illegal parameters N=%0d MOD=%0d", N, MOD);
   end

   localparam logic [N-1:0] c_LAST = N'(MOD - 64'd1);
   localparam logic [N-1:0] c_ZERO = '0;

   logic [N-1:0] w_count;
   logic [N-1:0] w_count_next;
   logic         w_count_we;
   logic         w_at_top;
   logic         w_at_zero;
   logic         w_tc;
   logic         w_ovf_next;
   logic         w_ovf;

   assign w_at_top  = (w_count == c_LAST);
   assign w_at_zero = (w_count == c_ZERO);
   // Unmasked by clr/load so it can feed the enable of a cascaded stage.
   assign w_tc      = bus.en & ((bus.up & w_at_top) | (~bus.up & w_at_zero));

   always_comb begin
      w_count_next = w_count;
      if (bus.clr) begin
         w_count_next = c_ZERO;
      end else if (bus.load) begin
         w_count_next = N'(clamp_load(32'(bus.din), MOD));
      end else if (bus.en) begin
         if (bus.up) begin
            if (w_at_top) w_count_next = (SAT == MODE_SAT) ? c_LAST : c_ZERO;
            else          w_count_next = w_count + N'(1);
         end else begin
            if (w_at_zero) w_count_next = (SAT == MODE_SAT) ? c_ZERO : c_LAST;
            else           w_count_next = w_count - N'(1);
         end
      end
   end

   assign w_count_we = bus.clr | bus.load | bus.en;
   assign w_ovf_next = w_tc & ~bus.clr & ~bus.load;

   ffd_en_arn #(.W(N)) u_count_reg (
      .clk    (clk),
      .arst_n (arst_n),
      .i_en   (w_count_we),
      .i_d    (w_count_next),
      .o_q    (w_count)
   );

   ffd_en_arn #(.W(1)) u_ovf_reg (
      .clk    (clk),
      .arst_n (arst_n),
      .i_en   (1'b1),
      .i_d    (w_ovf_next),
      .o_q    (w_ovf)
   );

   assign bus.count = w_count;
   assign bus.tc    = w_tc;
   assign bus.ovf   = w_ovf;
endmodule
`default_nettype wire

// File: tb/tb_counter_udm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_udm
//  Description : Self-checking bench for counter_udm (wrap, saturate, N=3).
//  Revision    : 1.0
// ============================================================================
module tb_counter_udm;
   typedef struct packed {
      logic [3:0] count;
      logic       tc;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   counter_udm_if #(.N(4)) ifa ();
   counter_udm_if #(.N(4)) ifb ();
   counter_udm_if #(.N(3)) ifc ();

   counter_udm #(.N(4), .MOD(10), .SAT(0)) u_dut_wrap (.clk(clk), .arst_n(arst_n), .bus(ifa.slave));
   counter_udm #(.N(4), .MOD(10), .SAT(1)) u_dut_sat  (.clk(clk), .arst_n(arst_n), .bus(ifb.slave));
   counter_udm #(.N(3), .MOD(8),  .SAT(0)) u_dut_mod8 (.clk(clk), .arst_n(arst_n), .bus(ifc.slave));

   task automatic test_reset();
      exp_t e;
      @(negedge clk);
      sb.push_back('{count: 4'd0, tc: 1'b0, ovf: 1'b0});
      sb.push_back('{count: 4'd0, tc: 1'b0, ovf: 1'b0});
      #1;
      e = sb.pop_front(); vectors++;
      if ({ifa.count, ifa.tc, ifa.ovf} !== e) begin
         miscompares++;
         $display("FAIL reset_a: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                  ifa.count, ifa.tc, ifa.ovf, e.count, e.tc, e.ovf);
      end
      e = sb.pop_front(); vectors++;
      if ({1'b0, ifc.count, ifc.tc, ifc.ovf} !== e) begin
         miscompares++;
         $display("FAIL reset_c: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                  ifc.count, ifc.tc, ifc.ovf, e.count, e.tc, e.ovf);
      end
      arst_n = 1'b1;
      @(negedge clk); ifa.load = 1'b1; ifa.din = 4'd7;
      @(negedge clk); ifa.load = 1'b0;
      sb.push_back('{count: 4'd7, tc: 1'b0, ovf: 1'b0});
      #1;
      e = sb.pop_front(); vectors++;
      if ({ifa.count, ifa.tc, ifa.ovf} !== e) begin
         miscompares++;
         $display("FAIL reset_preload: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                  ifa.count, ifa.tc, ifa.ovf, e.count, e.tc, e.ovf);
      end
      // Assert mid-cycle: the clear must land before any clock edge.
      @(posedge clk); #2 arst_n = 1'b0;
      sb.push_back('{count: 4'd0, tc: 1'b0, ovf: 1'b0});
      #1;
      e = sb.pop_front(); vectors++;
      if ({ifa.count, ifa.tc, ifa.ovf} !== e) begin
         miscompares++;
         $display("FAIL reset_async: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                  ifa.count, ifa.tc, ifa.ovf, e.count, e.tc, e.ovf);
      end
      ifa.load = 1'b1; ifa.din = 4'd5;
      @(posedge clk);
      sb.push_back('{count: 4'd0, tc: 1'b0, ovf: 1'b0});
      #1;
      e = sb.pop_front(); vectors++;
      if ({ifa.count, ifa.tc, ifa.ovf} !== e) begin
         miscompares++;
         $display("FAIL reset_hold: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                  ifa.count, ifa.tc, ifa.ovf, e.count, e.tc, e.ovf);
      end
      @(negedge clk); ifa.load = 1'b0; arst_n = 1'b1;
   endtask

   task automatic test_up_wrap();
      exp_t e;
      @(negedge clk); ifa.clr = 1'b1; ifa.en = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); ifa.clr = 1'b0; ifa.en = 1'b1; ifa.up = 1'b1;
         sb.push_back('{count: 4'(i % 10), tc: 1'((i % 10) == 9), ovf: 1'(i == 10)});
         #1;
         e = sb.pop_front(); vectors++;
         if ({ifa.count, ifa.tc, ifa.ovf} !== e) begin
            miscompares++;
            $display("FAIL up_wrap[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                     i, ifa.count, ifa.tc, ifa.ovf, e.count, e.tc, e.ovf);
         end
      end
      @(negedge clk); ifa.en = 1'b0;
   endtask

   task automatic test_down_wrap();
      exp_t       e;
      logic [3:0] cnt_t [5] = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
      logic       tc_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       ovf_t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      @(negedge clk); ifa.load = 1'b1; ifa.din = 4'd2; ifa.en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); ifa.load = 1'b0; ifa.en = 1'b1; ifa.up = 1'b0;
         sb.push_back('{count: cnt_t[i], tc: tc_t[i], ovf: ovf_t[i]});
         #1;
         e = sb.pop_front(); vectors++;
         if ({ifa.count, ifa.tc, ifa.ovf} !== e) begin
            miscompares++;
            $display("FAIL down_wrap[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                     i, ifa.count, ifa.tc, ifa.ovf, e.count, e.tc, e.ovf);
         end
      end
      @(negedge clk); ifa.en = 1'b0;
   endtask

   task automatic test_saturate();
      exp_t       e;
      logic       en_t  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       up_t  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] cnt_t [8] = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
      logic       tc_t  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic       ovf_t [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      @(negedge clk); ifb.load = 1'b1; ifb.din = 4'd8; ifb.en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); ifb.load = 1'b0; ifb.en = en_t[i]; ifb.up = up_t[i];
         sb.push_back('{count: cnt_t[i], tc: tc_t[i], ovf: ovf_t[i]});
         #1;
         e = sb.pop_front(); vectors++;
         if ({ifb.count, ifb.tc, ifb.ovf} !== e) begin
            miscompares++;
            $display("FAIL saturate[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                     i, ifb.count, ifb.tc, ifb.ovf, e.count, e.tc, e.ovf);
         end
      end
      @(negedge clk); ifb.en = 1'b0;
   endtask

   task automatic test_priority();
      exp_t        e;
      // {clr, load, din[3:0], en, up} driven; {count[3:0], tc, ovf} expected
      logic [13:0] rows [7] = '{
         {1'b0, 1'b1, 4'd13, 1'b0, 1'b1,  4'd0, 1'b0, 1'b0},
         {1'b0, 1'b1, 4'd4,  1'b1, 1'b1,  4'd9, 1'b1, 1'b0},
         {1'b0, 1'b1, 4'd9,  1'b0, 1'b1,  4'd4, 1'b0, 1'b0},
         {1'b1, 1'b0, 4'd0,  1'b1, 1'b1,  4'd9, 1'b1, 1'b0},
         {1'b0, 1'b1, 4'd9,  1'b0, 1'b1,  4'd0, 1'b0, 1'b0},
         {1'b0, 1'b0, 4'd0,  1'b1, 1'b0,  4'd9, 1'b0, 1'b0},
         {1'b0, 1'b0, 4'd0,  1'b0, 1'b0,  4'd8, 1'b0, 1'b0}};
      @(negedge clk); ifa.clr = 1'b1; ifa.load = 1'b1; ifa.din = 4'd5; ifa.en = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         {ifa.clr, ifa.load, ifa.din, ifa.en, ifa.up} = rows[i][13:6];
         sb.push_back(rows[i][5:0]);
         #1;
         e = sb.pop_front(); vectors++;
         if ({ifa.count, ifa.tc, ifa.ovf} !== e) begin
            miscompares++;
            $display("FAIL priority[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                     i, ifa.count, ifa.tc, ifa.ovf, e.count, e.tc, e.ovf);
         end
      end
   endtask

   task automatic test_edge_mod();
      exp_t e;
      @(negedge clk); ifc.clr = 1'b1; ifc.en = 1'b0;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         ifc.clr = 1'b0;
         ifc.up  = 1'b1;
         ifc.en  = (i < 10);
         ifc.load = (i == 10);
         ifc.din  = 3'd7;
         if (i < 10)       sb.push_back('{count: 4'(i % 8), tc: 1'((i % 8) == 7), ovf: 1'(i == 8)});
         else if (i == 10) sb.push_back('{count: 4'd2, tc: 1'b0, ovf: 1'b0});
         else              sb.push_back('{count: 4'd7, tc: 1'b0, ovf: 1'b0});
         #1;
         e = sb.pop_front(); vectors++;
         if ({1'b0, ifc.count, ifc.tc, ifc.ovf} !== e) begin
            miscompares++;
            $display("FAIL edge_mod[%0d]: got count=%0d tc=%b ovf=%b, want count=%0d tc=%b ovf=%b",
                     i, ifc.count, ifc.tc, ifc.ovf, e.count, e.tc, e.ovf);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      {ifa.clr, ifa.load, ifa.din, ifa.en, ifa.up} = '0;
      {ifb.clr, ifb.load, ifb.din, ifb.en, ifb.up} = '0;
      {ifc.clr, ifc.load, ifc.din, ifc.en, ifc.up} = '0;
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_priority();
      test_edge_mod();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
